// File: rtl/rtc_pkg.sv
// Shared RTC register map and scheduler state encoding.
package rtc_pkg;

  localparam logic [7:0] DIR_SEG_C  = 8'h21;
  localparam logic [7:0] DIR_MIN_C  = 8'h22;
  localparam logic [7:0] DIR_HORA_C = 8'h23;
  localparam logic [7:0] DIR_SEG_T  = 8'h41;
  localparam logic [7:0] DIR_MIN_T  = 8'h42;
  localparam logic [7:0] DIR_HORA_T = 8'h43;
  localparam logic [7:0] DIR_DIA    = 8'h24;
  localparam logic [7:0] DIR_MES    = 8'h25;
  localparam logic [7:0] DIR_ANO    = 8'h26;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_GO   = 3'd1,
    RD_WAIT = 3'd2,
    WR_GO   = 3'd3,
    WR_WAIT = 3'd4
  } sec_state_t;

endpackage

// File: rtl/rtc_refresh_tick.sv
// Free-running 0..PERIOD-1 counter; o_tick is high for the single cycle before the wrap.
module rtc_refresh_tick #(
  parameter int PERIOD = 10000000,
  parameter int W      = 24
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  logic [W-1:0] r_cnt;
  logic         w_wrap;

  assign w_wrap = (r_cnt == W'(PERIOD - 1));
  assign o_tick = w_wrap;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/rtc_secuenciador.sv
// RTC bus scheduler: periodic read bursts and on-demand write bursts, one bus owner at a time.
// Writes win over reads in IDLE; a stuck burst is aborted after TIMEOUT_CYCLES with a sticky flag.
module rtc_secuenciador
  import rtc_pkg::*;
#(
  parameter int REFRESH_CYCLES = 10000000,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Esc_req,
  input  logic       Term_Lect,
  input  logic       Term_Esc,
  input  logic       clk_timerL,
  output logic       Lectura,
  output logic       Escritura,
  output logic       En_clk,
  output logic [7:0] D_Seg,
  output logic [7:0] D_Min,
  output logic [7:0] D_Hora,
  output logic       Sel_Bus,
  output logic       Ocupado,
  output logic       Err_TO
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  sec_state_t      r_state;
  logic            r_rd_pend;
  logic            r_wr_pend;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_lectura;
  logic            r_escritura;
  logic            r_en_clk;
  logic            r_sel_bus;
  logic            r_ocupado;
  logic            r_err_to;
  logic            w_tick;
  logic            w_to;

  rtc_refresh_tick #(
    .PERIOD (REFRESH_CYCLES),
    .W      (CNT_W)
  ) u_refresh (
    .i_clk  (clk),
    .i_rst  (reset),
    .o_tick (w_tick)
  );

  // The increment that would land on TIMEOUT_CYCLES-1 is the one that aborts.
  assign w_to = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rd_pend   <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_to_cnt    <= '0;
      r_lectura   <= 1'b0;
      r_escritura <= 1'b0;
      r_en_clk    <= 1'b1;
      r_sel_bus   <= 1'b0;
      r_ocupado   <= 1'b0;
      r_err_to    <= 1'b0;
    end else begin
      r_lectura   <= 1'b0;
      r_escritura <= 1'b0;
      if (w_tick)  r_rd_pend <= 1'b1;
      if (Esc_req) r_wr_pend <= 1'b1;

      case (r_state)
        IDLE: begin
          if (r_wr_pend) begin
            r_state     <= WR_GO;
            r_escritura <= 1'b1;
            r_sel_bus   <= 1'b1;
          end else if (r_rd_pend) begin
            r_state   <= RD_GO;
            r_lectura <= 1'b1;
            r_sel_bus <= 1'b0;
            r_en_clk  <= 1'b1;
          end
        end
        // A request arriving in the GO cycle itself stays pending.
        RD_GO: begin
          r_state   <= RD_WAIT;
          r_ocupado <= 1'b1;
          r_to_cnt  <= '0;
          r_rd_pend <= w_tick;
        end
        RD_WAIT: begin
          if (Term_Lect || w_to) begin
            r_state   <= IDLE;
            r_ocupado <= 1'b0;
            r_en_clk  <= 1'b1;
            if (!Term_Lect) r_err_to <= 1'b1;
          end else begin
            r_en_clk <= ~clk_timerL;
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        WR_GO: begin
          r_state   <= WR_WAIT;
          r_ocupado <= 1'b1;
          r_to_cnt  <= '0;
          r_wr_pend <= Esc_req;
        end
        WR_WAIT: begin
          if (Term_Esc || w_to) begin
            r_state   <= IDLE;
            r_ocupado <= 1'b0;
            r_sel_bus <= 1'b0;
            if (!Term_Esc) r_err_to <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Lectura   = r_lectura;
  assign Escritura = r_escritura;
  assign En_clk    = r_en_clk;
  assign Sel_Bus   = r_sel_bus;
  assign Ocupado   = r_ocupado;
  assign Err_TO    = r_err_to;
  assign D_Seg     = r_en_clk ? DIR_SEG_C  : DIR_SEG_T;
  assign D_Min     = r_en_clk ? DIR_MIN_C  : DIR_MIN_T;
  assign D_Hora    = r_en_clk ? DIR_HORA_C : DIR_HORA_T;

endmodule

// File: tb/tb_rtc_secuenciador.sv
// Directed bench for rtc_secuenciador with REFRESH_CYCLES=20, TIMEOUT_CYCLES=16.
// Cycle n is the interval after the n-th rising edge following reset release; refresh counter reads n mod 20.
module tb_rtc_secuenciador;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Esc_req = 1'b0;
  logic       Term_Lect = 1'b0;
  logic       Term_Esc = 1'b0;
  logic       clk_timerL = 1'b0;
  logic       Lectura, Escritura, En_clk, Sel_Bus, Ocupado, Err_TO;
  logic [7:0] D_Seg, D_Min, D_Hora;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  rtc_secuenciador #(
    .REFRESH_CYCLES (20),
    .TIMEOUT_CYCLES (16),
    .CNT_W          (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Esc_req    (Esc_req),
    .Term_Lect  (Term_Lect),
    .Term_Esc   (Term_Esc),
    .clk_timerL (clk_timerL),
    .Lectura    (Lectura),
    .Escritura  (Escritura),
    .En_clk     (En_clk),
    .D_Seg      (D_Seg),
    .D_Min      (D_Min),
    .D_Hora     (D_Hora),
    .Sel_Bus    (Sel_Bus),
    .Ocupado    (Ocupado),
    .Err_TO     (Err_TO)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1; Esc_req = 1'b0; Term_Lect = 1'b0; Term_Esc = 1'b0; clk_timerL = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++; if (Lectura !== 1'b0)   begin bad++; $display("FAIL rst_lectura got=%b exp=0", Lectura); end
    total++; if (Escritura !== 1'b0) begin bad++; $display("FAIL rst_escritura got=%b exp=0", Escritura); end
    total++; if (En_clk !== 1'b1)    begin bad++; $display("FAIL rst_en_clk got=%b exp=1", En_clk); end
    total++; if (D_Seg !== 8'h21)    begin bad++; $display("FAIL rst_d_seg got=%h exp=21", D_Seg); end
    total++; if (D_Min !== 8'h22)    begin bad++; $display("FAIL rst_d_min got=%h exp=22", D_Min); end
    total++; if (D_Hora !== 8'h23)   begin bad++; $display("FAIL rst_d_hora got=%h exp=23", D_Hora); end
    total++; if (Sel_Bus !== 1'b0)   begin bad++; $display("FAIL rst_sel_bus got=%b exp=0", Sel_Bus); end
    total++; if (Ocupado !== 1'b0)   begin bad++; $display("FAIL rst_ocupado got=%b exp=0", Ocupado); end
    total++; if (Err_TO !== 1'b0)    begin bad++; $display("FAIL rst_err_to got=%b exp=0", Err_TO); end
  endtask

  // Wrap at edge 20 -> RD_GO in cycle 21; unanswered read aborts in cycle 37; next wrap -> Lectura at 41.
  task automatic test_idle_refresh();
    logic exp_l, exp_o, exp_e;
    do_reset();
    for (int n = 0; n <= 42; n++) begin
      exp_l = (n == 21) || (n == 41);
      exp_o = (n >= 22 && n <= 36) || (n == 42);
      exp_e = (n >= 37);
      total++; if (Lectura !== exp_l) begin bad++; $display("FAIL idle_lectura cyc=%0d got=%b exp=%b", n, Lectura, exp_l); end
      total++; if (Ocupado !== exp_o) begin bad++; $display("FAIL idle_ocupado cyc=%0d got=%b exp=%b", n, Ocupado, exp_o); end
      total++; if (Err_TO !== exp_e)  begin bad++; $display("FAIL idle_err_to cyc=%0d got=%b exp=%b", n, Err_TO, exp_e); end
      total++; if (Escritura !== 1'b0) begin bad++; $display("FAIL idle_escritura cyc=%0d got=%b exp=0", n, Escritura); end
      step();
    end
  endtask

  // Lectura at L=21, stray Term_Esc at L+3, clk_timerL=1 at L+5, Term_Lect at L+10.
  task automatic test_read_burst();
    do_reset();
    step_to(21);
    total++; if (Lectura !== 1'b1) begin bad++; $display("FAIL rd_lectura got=%b exp=1", Lectura); end
    total++; if (Sel_Bus !== 1'b0) begin bad++; $display("FAIL rd_sel_bus got=%b exp=0", Sel_Bus); end
    step_to(24);
    Term_Esc = 1'b1;
    step();
    Term_Esc = 1'b0;
    total++; if (Ocupado !== 1'b1) begin bad++; $display("FAIL rd_stray_term_esc got=%b exp=1", Ocupado); end
    step_to(26);
    clk_timerL = 1'b1;
    total++; if (En_clk !== 1'b1) begin bad++; $display("FAIL rd_en_clk_before got=%b exp=1", En_clk); end
    step();
    total++; if (En_clk !== 1'b0)  begin bad++; $display("FAIL rd_en_clk_after got=%b exp=0", En_clk); end
    total++; if (D_Seg !== 8'h41)  begin bad++; $display("FAIL rd_d_seg_t got=%h exp=41", D_Seg); end
    total++; if (D_Min !== 8'h42)  begin bad++; $display("FAIL rd_d_min_t got=%h exp=42", D_Min); end
    total++; if (D_Hora !== 8'h43) begin bad++; $display("FAIL rd_d_hora_t got=%h exp=43", D_Hora); end
    step_to(31);
    total++; if (Ocupado !== 1'b1) begin bad++; $display("FAIL rd_ocupado_term got=%b exp=1", Ocupado); end
    Term_Lect = 1'b1;
    step();
    Term_Lect = 1'b0;
    total++; if (En_clk !== 1'b1)  begin bad++; $display("FAIL rd_en_clk_end got=%b exp=1", En_clk); end
    total++; if (D_Seg !== 8'h21)  begin bad++; $display("FAIL rd_d_seg_end got=%h exp=21", D_Seg); end
    total++; if (Ocupado !== 1'b0) begin bad++; $display("FAIL rd_ocupado_end got=%b exp=0", Ocupado); end
    total++; if (Err_TO !== 1'b0)  begin bad++; $display("FAIL rd_err_to got=%b exp=0", Err_TO); end
    clk_timerL = 1'b0;
  endtask

  // Esc_req in cycle 19 and wrap at edge 20 together: write at 21, Term_Esc at 25, read at 27.
  task automatic test_write_priority();
    do_reset();
    step_to(19);
    Esc_req = 1'b1;
    step();
    Esc_req = 1'b0;
    step();
    total++; if (Escritura !== 1'b1) begin bad++; $display("FAIL pri_escritura got=%b exp=1", Escritura); end
    total++; if (Lectura !== 1'b0)   begin bad++; $display("FAIL pri_lectura got=%b exp=0", Lectura); end
    total++; if (Sel_Bus !== 1'b1)   begin bad++; $display("FAIL pri_sel_bus got=%b exp=1", Sel_Bus); end
    step_to(25);
    total++; if (Ocupado !== 1'b1) begin bad++; $display("FAIL pri_ocupado got=%b exp=1", Ocupado); end
    Term_Esc = 1'b1;
    step();
    Term_Esc = 1'b0;
    total++; if (Sel_Bus !== 1'b0) begin bad++; $display("FAIL pri_sel_bus_idle got=%b exp=0", Sel_Bus); end
    total++; if (Lectura !== 1'b0) begin bad++; $display("FAIL pri_lectura_gap got=%b exp=0", Lectura); end
    step();
    total++; if (Lectura !== 1'b1) begin bad++; $display("FAIL pri_lectura_after got=%b exp=1", Lectura); end
    total++; if (Sel_Bus !== 1'b0) begin bad++; $display("FAIL pri_sel_bus_rd got=%b exp=0", Sel_Bus); end
  endtask

  // Read at 21, Esc_req at 24, Term_Lect at 30 -> IDLE 31 -> Escritura at 32.
  task automatic test_write_during_read();
    do_reset();
    step_to(22);
    for (int n = 22; n <= 31; n++) begin
      total++; if (Sel_Bus !== 1'b0)   begin bad++; $display("FAIL wdr_sel_bus cyc=%0d got=%b exp=0", n, Sel_Bus); end
      total++; if (Escritura !== 1'b0) begin bad++; $display("FAIL wdr_escritura cyc=%0d got=%b exp=0", n, Escritura); end
      if (n == 24) Esc_req = 1'b1;
      if (n == 30) Term_Lect = 1'b1;
      step();
      Esc_req = 1'b0;
      Term_Lect = 1'b0;
    end
    total++; if (Escritura !== 1'b1) begin bad++; $display("FAIL wdr_escritura_late got=%b exp=1", Escritura); end
    total++; if (Sel_Bus !== 1'b1)   begin bad++; $display("FAIL wdr_sel_bus_late got=%b exp=1", Sel_Bus); end
  endtask

  // Escritura at 4 with no Term_Esc: abort visible at 20 (16 cycles later), refresh read at 21.
  task automatic test_timeout();
    do_reset();
    step_to(2);
    Esc_req = 1'b1;
    step();
    Esc_req = 1'b0;
    step_to(4);
    total++; if (Escritura !== 1'b1) begin bad++; $display("FAIL to_escritura got=%b exp=1", Escritura); end
    step_to(19);
    total++; if (Err_TO !== 1'b0)  begin bad++; $display("FAIL to_err_early got=%b exp=0", Err_TO); end
    total++; if (Sel_Bus !== 1'b1) begin bad++; $display("FAIL to_sel_bus_early got=%b exp=1", Sel_Bus); end
    step();
    total++; if (Err_TO !== 1'b1)  begin bad++; $display("FAIL to_err got=%b exp=1", Err_TO); end
    total++; if (Sel_Bus !== 1'b0) begin bad++; $display("FAIL to_sel_bus got=%b exp=0", Sel_Bus); end
    total++; if (Ocupado !== 1'b0) begin bad++; $display("FAIL to_ocupado got=%b exp=0", Ocupado); end
    step();
    total++; if (Lectura !== 1'b1) begin bad++; $display("FAIL to_lectura_next got=%b exp=1", Lectura); end
    total++; if (Err_TO !== 1'b1)  begin bad++; $display("FAIL to_err_sticky got=%b exp=1", Err_TO); end
  endtask

  // Reset mid write with a second write already pending: outputs drop at once, no request survives.
  task automatic test_reset_mid_write();
    do_reset();
    step_to(2);
    Esc_req = 1'b1;
    step();
    Esc_req = 1'b0;
    step_to(6);
    Esc_req = 1'b1;
    step();
    Esc_req = 1'b0;
    total++; if (Sel_Bus !== 1'b1) begin bad++; $display("FAIL rmw_sel_bus_pre got=%b exp=1", Sel_Bus); end
    total++; if (Ocupado !== 1'b1) begin bad++; $display("FAIL rmw_ocupado_pre got=%b exp=1", Ocupado); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (Sel_Bus !== 1'b0) begin bad++; $display("FAIL rmw_sel_bus got=%b exp=0", Sel_Bus); end
    total++; if (Ocupado !== 1'b0) begin bad++; $display("FAIL rmw_ocupado got=%b exp=0", Ocupado); end
    total++; if (En_clk !== 1'b1)  begin bad++; $display("FAIL rmw_en_clk got=%b exp=1", En_clk); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    for (int n = 0; n <= 20; n++) begin
      total++; if (Escritura !== 1'b0) begin bad++; $display("FAIL rmw_no_write cyc=%0d got=%b exp=0", n, Escritura); end
      total++; if (Lectura !== 1'b0)   begin bad++; $display("FAIL rmw_no_read cyc=%0d got=%b exp=0", n, Lectura); end
      step();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle_refresh();
    test_read_burst();
    test_write_priority();
    test_write_during_read();
    test_timeout();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
